// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports with write bypass, one write port,
// and a clear sweep after reset or clr_req. Define REGFILE_R0_ZERO_EN to hard-wire entry 0 to zero.
module regfile_param #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 5,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rw,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] busW,
    input  logic              clr_req,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic              ready
);
    localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                byp_a, byp_b;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready_q;
        we        = 1'b0;
        waddr     = rw;
        wdata     = busW;
        case (state_q)
            CLEAR: begin
                we        = 1'b1;
                waddr     = clr_ptr_q;
                wdata     = INIT_VAL;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                // a clear request wins over a write arriving on the same edge
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    ready_d   = 1'b0;
                end else if (reg_write && !(R0_ZERO && rw == '0)) begin
                    we = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N && we) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        byp_a = (state_q == IDLE) && reg_write && (rw == ra) && !(R0_ZERO && ra == '0);
        byp_b = (state_q == IDLE) && reg_write && (rw == rb) && !(R0_ZERO && rb == '0);
        busA  = '0;
        busB  = '0;
        if (ready_q) begin
            if (R0_ZERO && ra == '0) busA = '0;
            else if (byp_a)          busA = busW;
            else                     busA = regs_q[ra];
            if (R0_ZERO && rb == '0) busB = '0;
            else if (byp_b)          busB = busW;
            else                     busB = regs_q[rb];
        end
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed vector table, clear/reset sequences and randomized traffic
// checked against a sweep-countdown model of the register file.
module tb_regfile_param;
    localparam int          DEPTH = 32;
    localparam logic [31:0] INIT  = 32'hA5A5_0F0F;
`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  ra, rb, rw;
    logic        reg_write, clr_req;
    logic [31:0] busW, busA, busB;
    logic        ready;

    always #5 CLK = ~CLK;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .INIT_VAL(INIT)) dut (
        .CLK(CLK), .RST_N(RST_N), .ra(ra), .rb(rb), .rw(rw), .reg_write(reg_write),
        .busW(busW), .clr_req(clr_req), .busA(busA), .busB(busB), .ready(ready)
    );

    int checks = 0;
    int failures = 0;

    // reference: register contents plus the number of sweep edges still to come
    logic [31:0] mem [DEPTH];
    int          sweep_left;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (sweep_left != 0) return 32'h0;
        if (R0Z && a == 5'd0) return 32'h0;
        if (reg_write && rw == a) return busW;
        return mem[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!RST_N) begin
            sweep_left = DEPTH;
        end else if (sweep_left > 0) begin
            mem[DEPTH - sweep_left] = INIT;
            sweep_left--;
        end else if (clr_req) begin
            sweep_left = DEPTH;
        end else if (reg_write && !(R0Z && rw == 5'd0)) begin
            mem[rw] = busW;
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        chk("busA", busA, exp_rd(ra));
        chk("busB", busB, exp_rd(rb));
        chk("ready", 32'(ready), 32'(sweep_left == 0));
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        chk(name, 32'(n), 32'(DEPTH));
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  w_addr, a_addr, b_addr;
        logic [31:0] wd, ea, eb;
    } vec_t;

    vec_t tbl [8];

    initial begin
        RST_N = 1'b0; ra = '0; rb = '0; rw = '0; reg_write = 1'b0; busW = '0; clr_req = 1'b0;
        sweep_left = DEPTH;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_busA", busA, 32'h0);
        chk("rst_busB", busB, 32'h0);

        // writes during the sweep must be ignored
        RST_N = 1'b1; reg_write = 1'b1; rw = 5'd3; busW = 32'hFF; ra = 5'd3; rb = 5'd3;
        wait_ready("sweep_len");
        reg_write = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ra = 5'(a); rb = 5'(DEPTH - 1 - a);
            #1;
            chk("init_rd", busA, (R0Z && a == 0) ? 32'h0 : INIT);
            cycle();
        end
        ra = 5'd3;
        #1;
        chk("r3_ignored", busA, INIT);

        tbl[0] = '{1'b1, 5'd7,  5'd7, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 5'd31, 5'd7, 5'd31, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        tbl[2] = '{1'b0, 5'd0,  5'd7, 5'd31, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tbl[3] = '{1'b1, 5'd5,  5'd5, 5'd5,  32'h11,       32'h11,       32'h11};
        tbl[4] = '{1'b1, 5'd5,  5'd5, 5'd5,  32'h22,       32'h22,       32'h22};
        tbl[5] = '{1'b0, 5'd0,  5'd5, 5'd7,  32'h0,        32'h22,       32'hDEADBEEF};
        tbl[6] = '{1'b1, 5'd0,  5'd0, 5'd0,  32'h99,       R0Z ? 32'h0 : 32'h99, R0Z ? 32'h0 : 32'h99};
        tbl[7] = '{1'b0, 5'd0,  5'd0, 5'd5,  32'h0,        R0Z ? 32'h0 : 32'h99, 32'h22};
        for (int i = 0; i < 8; i++) begin
            reg_write = tbl[i].we; rw = tbl[i].w_addr; busW = tbl[i].wd;
            ra = tbl[i].a_addr; rb = tbl[i].b_addr;
            #1;
            chk("tbl_busA", busA, tbl[i].ea);
            chk("tbl_busB", busB, tbl[i].eb);
            cycle();
        end

        // clear request drops the simultaneous write to r2
        reg_write = 1'b1; rw = 5'd1; busW = 32'hAA; ra = 5'd1; rb = 5'd2;
        cycle();
        clr_req = 1'b1; rw = 5'd2; busW = 32'h55;
        cycle();
        clr_req = 1'b0; reg_write = 1'b0;
        wait_ready("clr_len");
        #1;
        chk("clr_r1", busA, INIT);
        chk("clr_r2", busB, INIT);

        // reset ten cycles into a sweep restarts it from entry 0
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (9) cycle();
        RST_N = 1'b0;
        cycle();
        RST_N = 1'b1;
        wait_ready("rst_restart");

        for (int i = 0; i < 1500; i++) begin
            RST_N     = ($urandom_range(0, 299) != 0);
            clr_req   = ($urandom_range(0, 79) == 0);
            reg_write = $urandom_range(0, 1);
            rw        = 5'($urandom_range(0, 31));
            busW      = $urandom;
            ra        = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            rb        = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the 32x32 processor register file: two asynchronous read ports, one synchronous write port, and a write-to-read bypass. Contents are cleared by an internal sweep sequencer after reset or on request, so no simulation-only initialisation is needed. A `ready` flag gates use of the file. The block sits in the decode stage of the MIPS datapath, feeding busA/busB to the ALU operand muxes and taking busW from writeback.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (derived, not overridable)
- INIT_VAL, 0, DATA_W-bit value written to every entry by the clear sweep

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  reset, synchronous, active-low
- ra  in  ADDR_W  read address, port A
- rb  in  ADDR_W  read address, port B
- rw  in  ADDR_W  write address
- reg_write  in  1  write enable
- busW  in  DATA_W  write data
- clr_req  in  1  single-cycle pulse that starts a clear sweep from IDLE
- busA  out  DATA_W  read data, port A
- busB  out  DATA_W  read data, port B
- ready  out  1  high when the file is in IDLE and accepts writes

## Operation
- The FSM has two states, CLEAR and IDLE, and a clear pointer `clr_ptr` of width ADDR_W.
- RST_N low at a rising edge: state <= CLEAR, clr_ptr <= 0, ready <= 0. No array write occurs on that edge.
- CLEAR, RST_N high: regs[clr_ptr] <= INIT_VAL, then clr_ptr <= clr_ptr+1.
  - When clr_ptr == DEPTH-1: the last entry is written, state <= IDLE, ready <= 1, and clr_ptr wraps to 0.
- IDLE: if reg_write = 1, then regs[rw] <= busW.
- IDLE with clr_req = 1: state <= CLEAR, clr_ptr <= 0, ready <= 0. If reg_write is also high on that edge, the write is dropped.
- CLEAR ignores reg_write and clr_req.
- Reads are combinational:
  - busA = regs[ra] and busB = regs[rb] when ready = 1.
  - Both buses are forced to 0 when ready = 0.
- Bypass: in IDLE with reg_write = 1 and rw == ra, busA = busW in the same cycle. busB behaves the same way on rw == rb. Both ports may bypass at once.
- Reset in the middle of a sweep restarts the sweep at entry 0.

## Timing
- Reset values: ready = 0, busA = 0, busB = 0, state = CLEAR, clr_ptr = 0.
- ready rises after the DEPTH-th rising edge with RST_N high that follows reset release (32 cycles at defaults). ready stays high until the next reset or clr_req.
- Write latency: data written at edge n is visible on an ordinary read after edge n. It is visible via bypass during cycle n, before the edge.
- A clr_req accepted at edge n drops ready after edge n. ready returns high after edge n+DEPTH.
- Read paths are combinational: no read latency and no registered outputs.

## Configuration
- REGFILE_R0_ZERO_EN defined:
  - Entry 0 reads as 0 whenever ready = 1.
  - Writes with rw == 0 are discarded.
  - No bypass is taken for address 0.
  - The sweep still clears entry 0.
- REGFILE_R0_ZERO_EN undefined: entry 0 is an ordinary register, and reads back INIT_VAL after a sweep.

## Test plan
- Reset sweep: hold RST_N low 3 cycles, then release. Require ready = 0 for exactly 32 edges, then 1. Require busA = 0 throughout the sweep, and every address afterwards reads INIT_VAL.
- Write then read: write 0xDEADBEEF to r7, read ra = 7 in the next cycle and require busA = 0xDEADBEEF. Write 0x12345678 to r31 and require busB = 0x12345678 via rb = 31.
- Bypass: hold r5 = 0x11, then write 0x22 to r5 with ra = rb = 5 in the same cycle. Require busA = busB = 0x22 before the edge.
- Writes ignored during CLEAR: assert reg_write with rw = 3 and busW = 0xFF during the sweep. After ready rises, require r3 = INIT_VAL.
- clr_req and reset mid-sweep:
  - Fill r1 = 0xAA, then pulse clr_req together with a write of 0x55 to r2. Require ready low for 32 cycles, then r1 = r2 = INIT_VAL.
  - Assert RST_N low at cycle 10 of a sweep. Require the full 32-cycle sweep to restart.
- With REGFILE_R0_ZERO_EN defined: write 0x99 to r0 with ra = 0. Require busA = 0 in the same cycle and afterwards. Without the macro, require busA = 0x99 via the bypass and on the next read.
